seq_div_sgn: RTL and testbench

Parametrised multi-cycle restoring divider. It succeeds the unsigned fixed-flow divider with three additions: a per-transaction signed/unsigned mode, explicit divide-by-zero and signed-overflow handling with early completion, and full valid/ready back-pressure on the result. It sits between a producer issuing operand pairs and a consumer draining quotient/remainder. The consumer is typically a datapath or a cocotb-driven bench.

---
 rtl/seq_div_pkg.sv | 33 +++
 rtl/div_step.sv | 23 ++
 rtl/seq_div_sgn.sv | 155 +++++++++++++++
 tb/tb_seq_div_sgn.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the signed/unsigned sequential divider.
// Helpers work on 64-bit containers, so WIDTH is limited to 2..64.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [63:0] min_pattern(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] neg(input logic [63:0] value);
        return ~value + 64'd1;
    endfunction

    // Magnitude of a width-bit value; the sign bit only matters in signed mode.
    function automatic logic [63:0] abs_val(input logic [63:0] value,
                                            input logic        signed_mode,
                                            input int          width);
        logic [63:0] mask;
        mask = (min_pattern(width) << 1) - 64'd1;
        if (signed_mode && ((value & min_pattern(width)) != 64'd0)) begin
            return neg(value) & mask;
        end else begin
            return value & mask;
        end
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes (combinational).
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] diff_s;
    logic             fits_s;

    assign shifted_s = {rem_i, quo_i[WIDTH-1]};
    assign diff_s    = {1'b0, shifted_s} - {2'b00, dvs_i};
    // Non-negative trial is always below the divisor, so both top bits are zero.
    assign fits_s    = (diff_s[WIDTH+1:WIDTH] == 2'b00);
    assign rem_o     = fits_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    assign quo_o     = {quo_i[WIDTH-2:0], fits_s};

endmodule

// File: rtl/seq_div_sgn.sv
// Multi-cycle restoring divider with signed/unsigned mode, special-case
// early completion and valid/ready back-pressure on the result.
module seq_div_sgn
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_mode,
    output logic             dest_valid,
    input  logic             dest_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_pattern(WIDTH));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] step_rem_s, step_quo_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem_s),
        .quo_o (step_quo_s)
    );

    // Next-state and datapath update for every state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (src_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = WIDTH'(abs_val(64'(divisor), signed_mode, WIDTH));
                    quo_d   = WIDTH'(abs_val(64'(dividend), signed_mode, WIDTH));
                    rem_d   = '0;
                    q_neg_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = signed_mode & dividend[WIDTH-1];
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        state_d = FIXUP;
                    end else if (signed_mode && (dividend == MIN_VAL) && (divisor == {WIDTH{1'b1}})) begin
                        ovf_d   = 1'b1;
                        state_d = FIXUP;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIXUP;
                end else begin
                    state_d = BUSY;
                end
            end
            FIXUP: begin
                if (dbz_q) begin
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dvd_q;
                end else if (ovf_q) begin
                    quotient_d  = MIN_VAL;
                    remainder_d = '0;
                end else begin
                    quotient_d  = q_neg_q ? WIDTH'(neg(64'(quo_q))) : quo_q;
                    remainder_d = r_neg_q ? WIDTH'(neg(64'(rem_q))) : rem_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (dest_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign src_ready   = (state_q == IDLE);
    assign dest_valid  = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div_sgn.sv
// Self-checking bench for seq_div_sgn: directed cases plus randomized
// transactions against a plain-arithmetic truncating-division model.
module tb_seq_div_sgn;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         src_valid;
    logic         src_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_mode;
    logic         dest_valid;
    logic         dest_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    seq_div_sgn #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_mode (signed_mode),
        .dest_valid  (dest_valid),
        .dest_ready  (dest_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on integers plus the special cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output logic ovf);
        longint sa, sb;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 16'h0000) begin
            q = 16'hFFFF; r = a; dbz = 1'b1;
        end else if (sm && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000; r = 16'h0000; ovf = 1'b1;
        end else if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                           input int bp, input logic rand_ready);
        logic [W-1:0] eq, er;
        logic         edbz, eovf;
        int           edges, wait_cnt, exp_lat;
        model(a, b, sm, eq, er, edbz, eovf);
        exp_lat = (edbz || eovf) ? 2 : W + 2;
        wait_cnt = 0;
        while (!src_ready && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end
        chk("src_ready_before_accept", 32'(src_ready), 32'd1);
        src_valid   = 1'b1;
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        dest_ready  = 1'b0;
        tick();
        edges = 1;
        src_valid   = 1'b0;
        dividend    = 16'($urandom);
        divisor     = 16'($urandom);
        signed_mode = 1'($urandom);
        chk("src_ready_low_after_accept", 32'(src_ready), 32'd0);
        while (!dest_valid && edges < 100) begin
            dest_ready = rand_ready ? 1'($urandom) : 1'b0;
            tick();
            edges++;
        end
        chk("latency", 32'(edges), 32'(exp_lat));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
        chk("overflow", 32'(overflow), 32'(eovf));
        for (int i = 0; i < bp; i++) begin
            dest_ready = 1'b0;
            tick();
            chk("bp_dest_valid", 32'(dest_valid), 32'd1);
            chk("bp_src_ready", 32'(src_ready), 32'd0);
            chk("bp_quotient", 32'(quotient), 32'(eq));
            chk("bp_remainder", 32'(remainder), 32'(er));
            chk("bp_flags", 32'({div_by_zero, overflow}), 32'({edbz, eovf}));
        end
        dest_ready = 1'b1;
        tick();
        dest_ready = 1'b0;
        chk("dest_valid_drop", 32'(dest_valid), 32'd0);
        chk("src_ready_back", 32'(src_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        int           sel;

        reset       = 1'b1;
        src_valid   = 1'b0;
        dividend    = '0;
        divisor     = '0;
        signed_mode = 1'b0;
        dest_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_src_ready", 32'(src_ready), 32'd1);
        chk("reset_dest_valid", 32'(dest_valid), 32'd0);
        chk("reset_outputs", 32'({quotient, remainder}), 32'd0);
        chk("reset_flags", 32'({div_by_zero, overflow}), 32'd0);

        run_txn(16'd56535, 16'd7, 1'b0, 0, 1'b0);
        chk("dir_unsigned_q", 32'(quotient), 32'h1F8C);
        run_txn(16'hFFF9, 16'h0002, 1'b1, 0, 1'b0);
        run_txn(16'hFFF9, 16'h0002, 1'b0, 0, 1'b0);
        run_txn(16'd100, 16'd0, 1'b0, 0, 1'b0);
        run_txn(16'd100, 16'd0, 1'b1, 0, 1'b0);
        run_txn(16'h8000, 16'hFFFF, 1'b1, 0, 1'b0);
        run_txn(16'h8000, 16'hFFFF, 1'b0, 0, 1'b0);
        run_txn(16'h8000, 16'h0003, 1'b1, 10, 1'b0);
        run_txn(16'h0007, 16'hFFFE, 1'b1, 0, 1'b0);

        // Abort in the middle of the iterations.
        src_valid   = 1'b1;
        dividend    = 16'd12345;
        divisor     = 16'd3;
        signed_mode = 1'b0;
        tick();
        src_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_src_ready", 32'(src_ready), 32'd1);
        chk("abort_dest_valid", 32'(dest_valid), 32'd0);
        chk("abort_outputs", 32'({quotient, remainder}), 32'd0);
        chk("abort_flags", 32'({div_by_zero, overflow}), 32'd0);
        for (int i = 0; i < 25; i++) tick();
        chk("abort_no_result", 32'(dest_valid), 32'd0);
        run_txn(16'd1000, 16'd10, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                rb = 16'h0000;
            end else if (sel == 1) begin
                ra = 16'h8000; rb = 16'hFFFF; rs = 1'b1;
            end else if (sel == 2) begin
                rb = 16'($urandom_range(1, 5));
            end else if (sel == 3) begin
                rb = 16'hFFFF - 16'($urandom_range(0, 3));
            end
            run_txn(ra, rb, rs, $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
